// File: rtl/hdlc_pkg.sv
// hdlc_pkg: encodings shared by the HDLC transmit path.
// Arbiter FSM states and the HDLC byte width.
package hdlc_pkg;

  localparam int HDLC_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_st_e;

endpackage

// File: rtl/rr_pick_onehot.sv
// rr_pick_onehot: round-robin pick starting after ptr.
// Rotate, priority-encode, rotate back; ptr itself is checked last.
module rr_pick_onehot #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] pick,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  localparam int SW = IDX_W + 1;

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [SW-1:0]       off;
  logic [SW-1:0]       sum;

  always_comb begin
    dbl   = {req, req};
    // rot[j] is req[(ptr + 1 + j) mod NUM_CH]
    rot   = NUM_CH'(dbl >> (ptr + 1));
    off   = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rot[j]) off = SW'(j);
    end
    sum   = off + {1'b0, ptr} + SW'(1);
    if (sum >= SW'(NUM_CH)) sum = sum - SW'(NUM_CH);
    idx   = sum[IDX_W-1:0];
    found = |req;
    pick  = found ? (NUM_CH'(1) << idx) : '0;
  end

endmodule

// File: rtl/hdlc_tx_pkt_arbiter.sv
// hdlc_tx_pkt_arbiter: packet-level round-robin mux onto one HDLC
// transmit stream, holding each grant to tlast, then an idle gap.
module hdlc_tx_pkt_arbiter
  import hdlc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ID_WIDTH  = 5,
  parameter int GAP_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            cfg_ch_en,
  input  logic [GAP_WIDTH-1:0]         cfg_gap,
  input  logic [NUM_CH*8-1:0]          s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  input  logic [NUM_CH*ID_WIDTH-1:0]   s_axis_tdest,
  output logic [7:0]                   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [ID_WIDTH-1:0]          m_axis_tid,
  output logic [ID_WIDTH-1:0]          m_axis_tdest,
  output logic [NUM_CH-1:0]            grant,
  output logic                         busy,
  output logic [31:0]                  pkt_cnt
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int BW    = HDLC_BYTE_W;

  arb_st_e               state_q;
  arb_st_e               state_d;
  logic [NUM_CH-1:0]     grant_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [GAP_WIDTH-1:0]  gap_cnt_q;
  logic [31:0]           pkt_cnt_q;

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     pick;
  logic [IDX_W-1:0]      pick_idx;
  logic                  found;
  logic                  hs;
  logic                  eof;
  logic                  gap_last;
  logic                  load;

  assign req = s_axis_tvalid & cfg_ch_en;

  rr_pick_onehot #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .idx   (pick_idx),
    .found (found)
  );

  assign hs  = m_axis_tvalid & m_axis_tready;
  assign eof = hs & m_axis_tlast;

  // The final gap cycle doubles as the arbitration cycle, so the
  // output stays quiet for exactly cfg_gap cycles between frames.
  assign gap_last = (state_q == ST_GAP) &&
                    (gap_cnt_q <= GAP_WIDTH'(1));
  assign load     = found &&
                    ((state_q == ST_IDLE) || gap_last);

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (found) state_d = ST_XFER;
      ST_XFER: begin
        if (eof)
          state_d = (cfg_gap != '0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_last)
          state_d = found ? ST_XFER : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      grant_q <= pick;
      ptr_q   <= pick_idx;
    end else if (eof) begin
      grant_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      gap_cnt_q <= '0;
    else if (eof)
      gap_cnt_q <= cfg_gap;
    else if (state_q == ST_GAP)
      gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn)    pkt_cnt_q <= '0;
    else if (eof) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  // ptr_q holds the granted index for the whole frame.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    if (state_q == ST_XFER) begin
      s_axis_tready[ptr_q] = m_axis_tready;
      m_axis_tvalid = s_axis_tvalid[ptr_q];
      m_axis_tlast  = s_axis_tlast[ptr_q];
      m_axis_tdata  = s_axis_tdata[ptr_q*BW +: BW];
      m_axis_tid    = ID_WIDTH'(ptr_q);
      m_axis_tdest  = s_axis_tdest[ptr_q*ID_WIDTH +: ID_WIDTH];
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != ST_IDLE);
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_hdlc_tx_pkt_arbiter.sv
// tb_hdlc_tx_pkt_arbiter: directed/random frames per channel checked
// against a round-robin frame-order model and per-cycle invariants.
module tb_hdlc_tx_pkt_arbiter;

  localparam int N   = 4;
  localparam int IDW = 5;
  localparam int GW  = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [N-1:0]      cfg_ch_en = '1;
  logic [GW-1:0]     cfg_gap = '0;
  logic [N*8-1:0]    s_axis_tdata = '0;
  logic [N-1:0]      s_axis_tvalid = '0;
  logic [N-1:0]      s_axis_tready;
  logic [N-1:0]      s_axis_tlast = '0;
  logic [N*IDW-1:0]  s_axis_tdest;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [IDW-1:0]    m_axis_tid;
  logic [IDW-1:0]    m_axis_tdest;
  logic [N-1:0]      grant;
  logic              busy;
  logic [31:0]       pkt_cnt;

  always #5 clk = ~clk;

  hdlc_tx_pkt_arbiter #(
    .NUM_CH(N), .ID_WIDTH(IDW), .GAP_WIDTH(GW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_ch_en(cfg_ch_en), .cfg_gap(cfg_gap),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdest(s_axis_tdest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  function automatic int dest_of(int ch);
    return (ch * 7 + 3) % 32;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dest
    assign s_axis_tdest[g*IDW +: IDW] = IDW'(dest_of(g));
  end

  typedef struct {
    int tid;
    int data;
    int last;
    int dest;
    int cyc;
  } beat_t;

  beat_t       obs[$];
  logic [8:0]  sq[N][$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        bubble_en = 1'b0;
  logic        bp_en = 1'b0;
  logic        only_ch2 = 1'b0;
  logic [N-1:0] drv_v = '0;
  logic [N-1:0] hs_r;
  logic        nv;
  logic        hold_v = 1'b0;
  logic [31:0] held;
  logic [31:0] cur;
  beat_t       bt;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // Round robin at frame granularity: first pending channel after ptr.
  function automatic int next_pick(int ptr, logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Source drivers, output monitor and per-cycle invariants.
  always begin
    @(negedge clk);
    hs_r = s_axis_tvalid & s_axis_tready;
    cur  = {17'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid};
    if (m_axis_tvalid && m_axis_tready) begin
      bt.tid  = int'(m_axis_tid);
      bt.data = int'(m_axis_tdata);
      bt.last = int'(m_axis_tlast);
      bt.dest = int'(m_axis_tdest);
      bt.cyc  = cyc;
      obs.push_back(bt);
    end
    if (rstn) begin
      chk("tready_outside_grant", 32'(s_axis_tready & ~grant), 32'd0);
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (only_ch2) chk("only_tready2", 32'(s_axis_tready & 4'b1011), 32'd0);
      if (hold_v) chk("stall_stable", cur, held);
    end
    hold_v = rstn && m_axis_tvalid && !m_axis_tready;
    held   = cur;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_r[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      if (drv_v[i] && !hs_r[i])
        nv = sq[i].size() > 0;
      else
        nv = (sq[i].size() > 0) && !(bubble_en && $urandom_range(0, 2) == 0);
      drv_v[i]            = nv;
      s_axis_tvalid[i]    = nv;
      s_axis_tlast[i]     = nv && sq[i][0][8];
      s_axis_tdata[i*8 +: 8] = nv ? sq[i][0][7:0] : 8'h00;
    end
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic wait_obs(input int n, input int budget);
    for (int k = 0; k < budget && obs.size() < n; k++) @(negedge clk);
    chk("beat_timeout", 32'(obs.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n0, n1, c, c0, k, d;
    int mptr;
    logic [31:0] exp_pkts;
    int order[$];
    int mdata[N][$];
    int pend[N];
    logic [N-1:0] m;

    mptr = 0;
    exp_pkts = 0;

    // 1: reset held with every source valid
    for (int i = 0; i < N; i++) sq[i].push_back({1'b1, 8'hA5});
    repeat (10) @(negedge clk);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_mdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tid", 32'(m_axis_tid), 32'd0);
    chk("rst_tdest", 32'(m_axis_tdest), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    for (int i = 0; i < N; i++) sq[i].delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 2: single channel, 10-byte frame, no gap
    cfg_gap = '0;
    n0 = obs.size();
    for (int b = 1; b <= 10; b++) sq[1].push_back({b == 10, 8'(b)});
    k = 0;
    while (!s_axis_tvalid[1] && k < 10) begin
      @(negedge clk);
      k++;
    end
    c0 = cyc;
    chk("t2_grant_pre", 32'(grant), 32'd0);
    @(negedge clk);
    chk("t2_grant_post", 32'(grant), 32'b0010);
    chk("t2_tready", 32'(s_axis_tready), 32'b0010);
    wait_obs(n0 + 10, 100);
    c = next_pick(mptr, 4'b0010);
    mptr = c;
    chk("t2_first_cyc", obs[n0].cyc, c0 + 1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_data", obs[n0+i].data, i + 1);
      chk("t2_tid", obs[n0+i].tid, c);
      chk("t2_last", obs[n0+i].last, 32'(i == 9));
      chk("t2_dest", obs[n0+i].dest, dest_of(c));
    end
    exp_pkts++;
    wait_idle(50);
    chk("t2_pkt_cnt", pkt_cnt, exp_pkts);

    // 3: all channels contend, two 4-byte frames each, gap 5
    cfg_gap = GW'(5);
    n0 = obs.size();
    for (int ch = 0; ch < N; ch++) begin
      pend[ch] = 2;
      for (int b = 0; b < 8; b++) begin
        d = $urandom_range(0, 255);
        mdata[ch].push_back(d);
        sq[ch].push_back({(b % 4) == 3, 8'(d)});
      end
    end
    order.delete();
    for (int f = 0; f < 2 * N; f++) begin
      for (int ch = 0; ch < N; ch++) m[ch] = pend[ch] > 0;
      c = next_pick(mptr, m);
      order.push_back(c);
      pend[c]--;
      mptr = c;
    end
    wait_obs(n0 + 8 * N, 1500);
    for (int f = 0; f < 2 * N; f++) begin
      c = order[f];
      for (int b = 0; b < 4; b++) begin
        chk("t3_tid", obs[n0+f*4+b].tid, c);
        chk("t3_data", obs[n0+f*4+b].data, mdata[c].pop_front());
        chk("t3_last", obs[n0+f*4+b].last, 32'(b == 3));
      end
      if (f > 0)
        chk("t3_gap", obs[n0+f*4].cyc - obs[n0+f*4-1].cyc - 1, 5);
    end
    exp_pkts += 8;
    wait_idle(100);
    chk("t3_pkt_cnt", pkt_cnt, exp_pkts);

    // 4: backpressure and source bubbles on a 16-byte ch2 frame
    cfg_gap = GW'(2);
    bp_en = 1'b1;
    bubble_en = 1'b1;
    only_ch2 = 1'b1;
    n0 = obs.size();
    for (int b = 0; b < 16; b++) begin
      d = $urandom_range(0, 255);
      mdata[2].push_back(d);
      sq[2].push_back({b == 15, 8'(d)});
    end
    c = next_pick(mptr, 4'b0100);
    mptr = c;
    wait_obs(n0 + 16, 2000);
    wait_idle(100);
    only_ch2 = 1'b0;
    bp_en = 1'b0;
    bubble_en = 1'b0;
    for (int b = 0; b < 16; b++) begin
      chk("t4_data", obs[n0+b].data, mdata[2].pop_front());
      chk("t4_tid", obs[n0+b].tid, c);
      chk("t4_last", obs[n0+b].last, 32'(b == 15));
    end
    exp_pkts++;
    chk("t4_pkt_cnt", pkt_cnt, exp_pkts);

    // 5a: disabling the granted channel mid-frame does not abort it
    cfg_gap = '0;
    n0 = obs.size();
    for (int b = 0; b < 8; b++) sq[3].push_back({b == 7, 8'(8'h30 + b)});
    c = next_pick(mptr, 4'b1000);
    mptr = c;
    wait_obs(n0 + 2, 200);
    cfg_ch_en[3] = 1'b0;
    wait_obs(n0 + 8, 200);
    for (int b = 0; b < 8; b++) begin
      chk("t5_data", obs[n0+b].data, 8'h30 + b);
      chk("t5_tid", obs[n0+b].tid, c);
      chk("t5_last", obs[n0+b].last, 32'(b == 7));
    end
    exp_pkts++;
    wait_idle(50);
    chk("t5_pkt_cnt", pkt_cnt, exp_pkts);

    // 5b: reset at beat 3 of the next frame truncates it
    n1 = obs.size();
    for (int b = 0; b < 8; b++) sq[0].push_back({b == 7, 8'(8'h50 + b)});
    c = next_pick(mptr, 4'b0001);
    wait_obs(n1 + 3, 200);
    rstn = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      chk("t5b_data", obs[n1+b].data, 8'h50 + b);
      chk("t5b_tid", obs[n1+b].tid, c);
    end
    chk("t5b_tready", 32'(s_axis_tready), 32'd0);
    chk("t5b_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t5b_grant", 32'(grant), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd0);
    chk("t5b_pkt_cnt", pkt_cnt, 32'd0);
    for (int i = 0; i < N; i++) sq[i].delete();
    mptr = 0;
    exp_pkts = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 5c: a disabled channel is never newly granted
    sq[3].push_back({1'b1, 8'h77});
    repeat (6) @(negedge clk);
    chk("t5c_grant", 32'(grant), 32'd0);
    chk("t5c_busy", 32'(busy), 32'd0);
    sq[3].delete();
    @(negedge clk);
    @(negedge clk);
    cfg_ch_en = '1;

    // 6: counter wrap with a single-beat frame
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_cnt_q;
    @(negedge clk);
    chk("t6_preload", pkt_cnt, 32'hFFFF_FFFF);
    n0 = obs.size();
    d = $urandom_range(0, 255);
    sq[2].push_back({1'b1, 8'(d)});
    c = next_pick(mptr, 4'b0100);
    wait_obs(n0 + 1, 50);
    wait_idle(50);
    chk("t6_data", obs[n0].data, d);
    chk("t6_tid", obs[n0].tid, c);
    chk("t6_last", obs[n0].last, 1);
    exp_pkts = 32'hFFFF_FFFF;
    exp_pkts = exp_pkts + 32'd1;
    chk("t6_wrap", pkt_cnt, exp_pkts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
